// File: rtl/prf_alloc_ctrl.sv
// prf_alloc_ctrl: sequencing controller for the physical-register free list.
// Owns the head / tail / architectural-head pointers and the free count of an
// external FL_DEPTH-entry circular free-list RAM. After reset it fills the
// RAM with pregs ARCHREG..PHYREG-1. It then grants rename allocations on an
// all-or-nothing basis and compacts commit-time frees into RAM writes. On a
// flush it restores the speculative head from the architectural head.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rename_req          per-slot allocation request
//   alloc_grant         every requested slot granted this cycle
//   stall_o             rename must hold
//   fl_raddr            RAM read index per rename slot (combinational from head)
//   commit_free_valid   per commit slot: an old preg is released
//   commit_free_preg    preg released by each commit slot
//   commit_alloc        per commit slot: the instruction had allocated a preg
//   fl_we/waddr/wdata   RAM write ports (compacted frees, or init fill)
//   flush_i             pipeline flush
//   free_count_o        current free count
//   ready_o             initialisation complete
//   overflow_err_o      sticky free-overflow error
module prf_alloc_ctrl #(
  parameter  int PHYREG       = 64,
  parameter  int ARCHREG      = 32,
  parameter  int RENAME_WIDTH = 2,
  parameter  int COMMIT_WIDTH = 2,
  localparam int PREG_W       = $clog2(PHYREG),
  localparam int FL_DEPTH     = PHYREG - ARCHREG,
  localparam int PTR_W        = $clog2(FL_DEPTH),
  localparam int CNT_W        = $clog2(FL_DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [RENAME_WIDTH-1:0]                  rename_req,
  output logic                                     alloc_grant,
  output logic                                     stall_o,
  output logic [RENAME_WIDTH-1:0][PTR_W-1:0]       fl_raddr,
  input  logic [COMMIT_WIDTH-1:0]                  commit_free_valid,
  input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]      commit_free_preg,
  input  logic [COMMIT_WIDTH-1:0]                  commit_alloc,
  output logic [COMMIT_WIDTH-1:0]                  fl_we,
  output logic [COMMIT_WIDTH-1:0][PTR_W-1:0]       fl_waddr,
  output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]      fl_wdata,
  input  logic                                     flush_i,
  output logic [CNT_W-1:0]                         free_count_o,
  output logic                                     ready_o,
  output logic                                     overflow_err_o
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_RECOVER} state_t;

  state_t            state, state_next;
  // Pointers carry one extra wrap bit so tail - head distinguishes full from empty.
  logic [PTR_W:0]    head, tail, arch_head;
  logic [PTR_W:0]    head_next, tail_next, arch_next, rec_diff;
  logic [PTR_W-1:0]  init_idx;
  logic [CNT_W-1:0]  count, count_next;
  logic [CNT_W:0]    run_sum;
  logic [CNT_W-1:0]  n_req, n_free, n_ca;
  logic              grant, ovf, ovf_set;

  // Read indices, compacted write ports and popcounts.
  always_comb begin
    n_req    = '0;
    n_free   = '0;
    n_ca     = '0;
    fl_raddr = '0;
    fl_we    = '0;
    fl_waddr = '0;
    fl_wdata = '0;
    for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
      if (state != S_INIT)
        fl_raddr[k] = head[PTR_W-1:0] + n_req[PTR_W-1:0];
      n_req = n_req + CNT_W'(rename_req[k]);
    end
    if (state == S_INIT) begin
      // Gated by rst so the write port stays quiet while reset is held.
      if (rst) begin
        fl_we[0]    = 1'b1;
        fl_waddr[0] = init_idx;
        fl_wdata[0] = PREG_W'(ARCHREG) + PREG_W'(init_idx);
      end
    end else begin
      // j-th valid commit slot lands on write port n_free (slot-order compaction).
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_free_valid[j]) begin
          for (int unsigned p = 0; p < COMMIT_WIDTH; p++) begin
            if (n_free == CNT_W'(p)) begin
              fl_we[p]    = 1'b1;
              fl_waddr[p] = tail[PTR_W-1:0] + n_free[PTR_W-1:0];
              fl_wdata[p] = commit_free_preg[j];
            end
          end
        end
        n_free = n_free + CNT_W'(commit_free_valid[j]);
      end
    end
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++)
      n_ca = n_ca + CNT_W'(commit_alloc[j]);
  end

  // Grant decision and next pointer / count values for RUN and RECOVER.
  always_comb begin
    grant      = (state == S_RUN) && !flush_i && (n_req != '0) && (n_req <= count);
    stall_o    = (state != S_RUN) || (n_req > count);
    tail_next  = tail + (PTR_W+1)'(n_free);
    arch_next  = arch_head + (PTR_W+1)'(n_ca);
    head_next  = flush_i ? arch_next
                         : head + (grant ? (PTR_W+1)'(n_req) : '0);
    state_next = flush_i ? S_RECOVER : S_RUN;
    run_sum    = {1'b0, count} - (grant ? {1'b0, n_req} : '0) + {1'b0, n_free};
    rec_diff   = tail_next - head_next;
    ovf_set    = 1'b0;
    count_next = count;
    if (state == S_RECOVER) begin
      if (rec_diff > (PTR_W+1)'(FL_DEPTH)) begin
        ovf_set    = 1'b1;
        count_next = CNT_W'(FL_DEPTH);
      end else begin
        count_next = CNT_W'(rec_diff);
      end
    end else if (run_sum > (CNT_W+1)'(FL_DEPTH)) begin
      ovf_set    = 1'b1;
      count_next = CNT_W'(FL_DEPTH);
    end else begin
      count_next = CNT_W'(run_sum);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      head      <= '0;
      tail      <= '0;
      arch_head <= '0;
      count     <= '0;
      init_idx  <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == PTR_W'(FL_DEPTH - 1)) begin
            tail  <= (PTR_W+1)'(FL_DEPTH);
            count <= CNT_W'(FL_DEPTH);
            state <= S_RUN;
          end
        end
        default: begin
          head      <= head_next;
          tail      <= tail_next;
          arch_head <= arch_next;
          count     <= count_next;
          state     <= state_next;
          if (ovf_set) ovf <= 1'b1;
        end
      endcase
    end
  end

  assign alloc_grant    = grant;
  assign free_count_o   = count;
  assign ready_o        = (state != S_INIT);
  assign overflow_err_o = ovf;

endmodule

// File: tb/tb_prf_alloc_ctrl.sv
module tb_prf_alloc_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int PW    = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          rename_req;
  logic                alloc_grant, stall_o;
  logic [1:0][AW-1:0]  fl_raddr;
  logic [1:0]          commit_free_valid;
  logic [1:0][PW-1:0]  commit_free_preg;
  logic [1:0]          commit_alloc;
  logic [1:0]          fl_we;
  logic [1:0][AW-1:0]  fl_waddr;
  logic [1:0][PW-1:0]  fl_wdata;
  logic                flush_i;
  logic [5:0]          free_count_o;
  logic                ready_o, overflow_err_o;

  always #5 clk = ~clk;

  prf_alloc_ctrl #(.PHYREG(64), .ARCHREG(32), .RENAME_WIDTH(2), .COMMIT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .rename_req(rename_req), .alloc_grant(alloc_grant),
    .stall_o(stall_o), .fl_raddr(fl_raddr), .commit_free_valid(commit_free_valid),
    .commit_free_preg(commit_free_preg), .commit_alloc(commit_alloc), .fl_we(fl_we),
    .fl_waddr(fl_waddr), .fl_wdata(fl_wdata), .flush_i(flush_i),
    .free_count_o(free_count_o), .ready_o(ready_o), .overflow_err_o(overflow_err_o)
  );

  typedef struct {
    logic               init_ph;
    logic               grant, stall, ready, ovf;
    logic [5:0]         cnt;
    logic [1:0][AW-1:0] raddr;
    logic [1:0]         we;
    logic [1:0][AW-1:0] waddr;
    logic [1:0][PW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: unbounded integer pointers, addresses taken mod DEPTH.
  int m_head, m_tail, m_arch, m_cnt;
  bit m_rec, m_ovf;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [1:0] keep_low(input logic [1:0] m, input int k);
    logic [1:0] r = '0;
    int c = 0;
    for (int i = 0; i < 2; i++)
      if (m[i] && c < k) begin r[i] = 1'b1; c++; end
    return r;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] fv, input logic [PW-1:0] p0,
                       input logic [PW-1:0] p1, input logic [1:0] ca, input logic fl);
    exp_t e;
    int n, f, c, pos;
    logic [PW-1:0] pr [2];
    pr[0] = p0; pr[1] = p1;
    n = $countones(req); f = $countones(fv); c = $countones(ca);
    e.init_ph = 1'b0; e.ready = 1'b1; e.ovf = m_ovf; e.cnt = 6'(m_cnt);
    e.grant = !m_rec && !fl && n > 0 && n <= m_cnt;
    e.stall = m_rec || n > m_cnt;
    pos = 0;
    for (int k = 0; k < 2; k++) begin
      e.raddr[k] = AW'((m_head + pos) % DEPTH);
      if (req[k]) pos++;
    end
    e.we = '0; e.waddr = '0; e.wdata = '0; pos = 0;
    for (int j = 0; j < 2; j++)
      if (fv[j]) begin
        for (int p = 0; p < 2; p++)
          if (p == pos) begin
            e.we[p] = 1'b1;
            e.waddr[p] = AW'((m_tail + pos) % DEPTH);
            e.wdata[p] = pr[j];
          end
        pos++;
      end
    m_arch += c;
    m_tail += f;
    if (fl) m_head = m_arch;
    else if (e.grant) m_head += n;
    if (m_rec) m_cnt = m_tail - m_head;
    else begin
      m_cnt = m_cnt - (e.grant ? n : 0) + f;
      if (m_cnt > DEPTH) begin m_ovf = 1'b1; m_cnt = DEPTH; end
    end
    m_rec = fl;
    rename_req = req; commit_free_valid = fv; commit_free_preg[0] = p0;
    commit_free_preg[1] = p1; commit_alloc = ca; flush_i = fl;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle(input int flush_pct);
    logic [1:0] fv, ca;
    fv = keep_low(2'($urandom_range(0, 3)), DEPTH - (m_tail - m_arch));
    ca = keep_low(2'($urandom_range(0, 3)), m_head - m_arch);
    drive(2'($urandom_range(0, 3)), fv, PW'($urandom_range(0, 63)), PW'($urandom_range(0, 63)),
          ca, $urandom_range(0, 99) < flush_pct);
  endtask

  // Init fill with random (ignored) inputs; RUN model state afterwards.
  task automatic do_init();
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      rename_req = 2'($urandom_range(0, 3)); commit_free_valid = 2'($urandom_range(0, 3));
      commit_free_preg[0] = PW'($urandom_range(0, 63)); commit_free_preg[1] = PW'($urandom_range(0, 63));
      commit_alloc = 2'($urandom_range(0, 3)); flush_i = 1'($urandom_range(0, 1));
      e.init_ph = 1'b1; e.grant = 1'b0; e.stall = 1'b1; e.ready = 1'b0; e.ovf = 1'b0;
      e.cnt = '0; e.raddr = '0; e.we = 2'b01;
      e.waddr = '0; e.waddr[0] = AW'(i);
      e.wdata = '0; e.wdata[0] = PW'(32 + i);
      sb.push_back(e);
      @(posedge clk); #1;
    end
    m_head = 0; m_tail = DEPTH; m_arch = 0; m_cnt = DEPTH; m_rec = 0; m_ovf = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic reset_checks();
    chk("rst_stall", 32'(stall_o), 32'd1);
    chk("rst_grant", 32'(alloc_grant), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_count", 32'(free_count_o), 32'd0);
    chk("rst_ovf", 32'(overflow_err_o), 32'd0);
    chk("rst_we", 32'(fl_we), 32'd0);
    chk("rst_raddr", 32'(fl_raddr), 32'd0);
    chk("rst_waddr", 32'(fl_waddr), 32'd0);
    chk("rst_wdata", 32'(fl_wdata), 32'd0);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alloc_grant", 32'(alloc_grant), 32'(e.grant));
        chk("stall_o", 32'(stall_o), 32'(e.stall));
        chk("ready_o", 32'(ready_o), 32'(e.ready));
        chk("overflow_err_o", 32'(overflow_err_o), 32'(e.ovf));
        chk("free_count_o", 32'(free_count_o), 32'(e.cnt));
        chk("fl_we", 32'(fl_we), 32'(e.we));
        if (e.init_ph) begin
          chk("init_waddr", 32'(fl_waddr), 32'(e.waddr));
          chk("init_wdata", 32'(fl_wdata), 32'(e.wdata));
        end else begin
          chk("fl_raddr", 32'(fl_raddr), 32'(e.raddr));
          for (int p = 0; p < 2; p++)
            if (e.we[p]) begin
              chk("fl_waddr", 32'(fl_waddr[p]), 32'(e.waddr[p]));
              chk("fl_wdata", 32'(fl_wdata[p]), 32'(e.wdata[p]));
            end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rename_req = 2'b11; commit_free_valid = '0; commit_free_preg = '0;
    commit_alloc = '0; flush_i = 1'b0;
    #7;
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b1;
    do_init();

    // First allocations: raddr {1,0}, then slot 1 alone reads head 2.
    drive(2'b11, 2'b00, '0, '0, 2'b00, 1'b0);
    drive(2'b10, 2'b00, '0, '0, 2'b00, 1'b0);
    // Drain to one free entry while committing outstanding allocations.
    while (m_cnt > 2) drive(2'b11, 2'b00, '0, '0, keep_low(2'b11, m_head - m_arch), 1'b0);
    // Same-cycle free cannot satisfy the request; next cycle grants.
    drive(2'b11, 2'b01, 6'd7, '0, 2'b00, 1'b0);
    drive(2'b11, 2'b00, '0, '0, 2'b00, 1'b0);

    repeat (600) rand_cycle(6);

    // Fill to full, flush, confirm full survives recovery, then overflow.
    while (m_head - m_arch > 0 || m_rec)
      drive(2'b00, 2'b00, '0, '0, keep_low(2'b11, m_head - m_arch), 1'b0);
    while (m_tail - m_arch < DEPTH)
      drive(2'b00, keep_low(2'b11, DEPTH - (m_tail - m_arch)), 6'd9, 6'd10, 2'b00, 1'b0);
    drive(2'b00, 2'b00, '0, '0, 2'b00, 1'b1);
    drive(2'b00, 2'b00, '0, '0, 2'b00, 1'b0);
    drive(2'b00, 2'b01, 6'd11, '0, 2'b00, 1'b0);
    drive(2'b00, 2'b00, '0, '0, 2'b00, 1'b0);
    drive(2'b01, 2'b00, '0, '0, 2'b00, 1'b0);
    wait_drain();

    // Asynchronous reset mid-operation.
    #2 rst = 1'b0;
    #1 reset_checks();
    @(posedge clk); #1;
    rst = 1'b1;
    do_init();

    // Allocate 6, commit 2, flush with one more commit: head restores to 3.
    drive(2'b11, 2'b00, '0, '0, 2'b00, 1'b0);
    drive(2'b11, 2'b00, '0, '0, 2'b11, 1'b0);
    drive(2'b11, 2'b00, '0, '0, 2'b00, 1'b0);
    drive(2'b00, 2'b00, '0, '0, 2'b01, 1'b1);
    drive(2'b01, 2'b00, '0, '0, 2'b00, 1'b0);
    drive(2'b00, 2'b00, '0, '0, 2'b00, 1'b0);

    repeat (200) rand_cycle(10);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prf_alloc_ctrl.md
Name: prf_alloc_ctrl

Overview:
- Sequencing controller for the physical-register free list: owns head, tail, architectural-head pointers and free count for an external FL_DEPTH-entry circular free-list RAM.
- Grants rename allocations all-or-nothing, steers commit-time frees into the RAM, and initialises the RAM after reset.
- Restores the speculative head on pipeline flush.
- Sits between the rename stage and the free-list storage; the ROB commit port feeds it.

Parameters:
- PHYREG, 64, number of physical registers; PREG_W = $clog2(PHYREG).
- ARCHREG, 32, number of architectural registers.
- RENAME_WIDTH, 2, rename slots per cycle.
- COMMIT_WIDTH, 2, commit slots per cycle.
- Derived: FL_DEPTH = PHYREG-ARCHREG; must be a power of two. PTR_W = $clog2(FL_DEPTH). CNT_W = $clog2(FL_DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- rename_req  in  RENAME_WIDTH  per-slot allocation request; any bit pattern is legal.
- alloc_grant  out  1  all requested slots granted this cycle.
- stall_o  out  1  rename must hold.
- fl_raddr  out  RENAME_WIDTH x PTR_W  RAM read index per slot.
- commit_free_valid  in  COMMIT_WIDTH  committed instruction releases an old preg.
- commit_free_preg  in  COMMIT_WIDTH x PREG_W  preg being released.
- commit_alloc  in  COMMIT_WIDTH  committed instruction had allocated a preg.
- fl_we  out  COMMIT_WIDTH  RAM write enables.
- fl_waddr  out  COMMIT_WIDTH x PTR_W  RAM write indices.
- fl_wdata  out  COMMIT_WIDTH x PREG_W  RAM write data.
- flush_i  in  1  pipeline flush (mispredict or exception).
- free_count_o  out  CNT_W  current free count.
- ready_o  out  1  initialisation complete.
- overflow_err_o  out  1  sticky free-overflow error.

Behaviour:
- Reset (rst low, async):
  - state=INIT; head=tail=arch_head=0; count=0; init_idx=0.
  - All outputs 0, except stall_o=1.
- INIT state:
  - Each cycle: fl_we[0]=1, fl_waddr[0]=init_idx, fl_wdata[0]=ARCHREG+init_idx. Other write ports are 0.
  - Exactly FL_DEPTH cycles. On the last write: tail=0 (wrapped), count=FL_DEPTH, state→RUN.
  - ready_o=1 from the first RUN cycle.
  - rename_req, commit inputs and flush_i are ignored. stall_o=1 throughout.
- RUN, allocation:
  - n = popcount(rename_req).
  - For each slot k: fl_raddr[k] = head + (number of set rename_req bits below k), mod FL_DEPTH. fl_raddr is combinational from head.
  - n>0 and n<=count and !flush_i: alloc_grant=1, head += n (wraps mod FL_DEPTH).
  - n>count: alloc_grant=0, stall_o=1, head unchanged. There is no partial grant.
  - n=0: alloc_grant=0, stall_o=0.
- RUN, free:
  - f = popcount(commit_free_valid).
  - Valid commit slots are compacted in slot order to tail, tail+1, …: fl_we[j] set for the first f write ports, fl_wdata = the corresponding preg.
  - tail += f. Writes are combinational same-cycle outputs.
- arch_head: arch_head += popcount(commit_alloc) every RUN and RECOVER cycle.
- Count: count_next = count - (granted ? n : 0) + f.
  - Allocation uses the pre-update count; a same-cycle free cannot satisfy a same-cycle request.
  - If count - alloc + f > FL_DEPTH: overflow_err_o=1 (sticky until reset), count saturates at FL_DEPTH, writes still issued.
- Flush (RUN, flush_i=1):
  - No grant that cycle. State→RECOVER.
  - Next head = arch_head + popcount(commit_alloc) of the same cycle.
  - Frees of that cycle are still applied.
- RECOVER (exactly 1 cycle):
  - stall_o=1, alloc_grant=0.
  - Frees and commit_alloc are processed normally.
  - count = (tail_next - head) mod FL_DEPTH. If the result is 0 and the pre-flush free state was full, count=FL_DEPTH; a separate wrap bit per pointer resolves the full/empty ambiguity.
  - State→RUN.
  - flush_i in RECOVER: stays one more RECOVER cycle and re-snapshots arch_head.
- flush_i in INIT: ignored.
- free_count_o is a registered copy of count.
- Async reset mid-operation returns to INIT and re-initialises the whole RAM.

Test Plan:
- Release rst → fl_we[0] pulses 32 cycles with wdata 32..63, waddr 0..31; ready_o rises on cycle 33; free_count_o=32.
- RUN, rename_req=2'b11 → alloc_grant=1, fl_raddr={1,0}; next cycle head=2, free_count_o=30. Then rename_req=2'b10 → fl_raddr[1]=2.
- Drain to count=1, rename_req=2'b11 with commit_free_valid=2'b01 same cycle → alloc_grant=0, stall_o=1, count becomes 2. Next cycle grants.
- Allocate 6, commit_alloc 2, flush_i with commit_alloc=2'b01 → head restores to 3, RECOVER 1 cycle with stall_o=1, count recomputed = tail-3.
- Repeated allocate and free to cross index 31→0 → fl_raddr and fl_waddr wrap to 0; a full list (count 32) still reported correctly after flush.
- At count=32, commit_free_valid=2'b01 → overflow_err_o=1 and stays 1; count stays 32.
